// File: rtl/twos_rca_nbit_pkg.sv
// Shared constants and bit-level helpers for the ripple-carry adder/subtractor.
package twos_rca_nbit_pkg;

  localparam int DEFAULT_N = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic xor3(input logic a, input logic b, input logic c);
    xor3 = a ^ b ^ c;
  endfunction

endpackage

// File: rtl/twos_rca_nbit_full_adder.sv
// Single-bit full adder cell used as one stage of the ripple chain.
module twos_rca_nbit_full_adder
  import twos_rca_nbit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = xor3(a, b, ci);
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/twos_rca_nbit.sv
// N-bit two's-complement adder/subtractor: S = sext(A) +/- sext(B), exact N+1-bit
// result registered on every rising clk edge; cin = 1 selects subtraction.
module twos_rca_nbit
  import twos_rca_nbit_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N:0]   S
);

  logic [N-1:0] bx_s;
  logic [N-1:0] sum_s;
  logic [N:0]   c_s;
  logic         msb_s;
  logic [N:0]   s_d;
  logic [N:0]   s_q;

  assign bx_s   = B ^ {N{cin}};
  assign c_s[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_stage
    twos_rca_nbit_full_adder u_fa (
      .a  (A[i]),
      .b  (bx_s[i]),
      .ci (c_s[i]),
      .s  (sum_s[i]),
      .co (c_s[i+1])
    );
  end

  // Extra stage over the sign-extended operands; the raw carry-out would give a wrong sign.
  assign msb_s = xor3(A[N-1], bx_s[N-1], c_s[N]);

  always_comb begin
    s_d = {msb_s, sum_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= {(N+1){1'b0}};
    end else begin
      s_q <= s_d;
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_twos_rca_nbit.sv
// Self-checking bench for twos_rca_nbit (N = 32) against a signed-arithmetic reference.
module tb_twos_rca_nbit;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic [N:0]   S;

  int n_checks;
  int n_fails;

  twos_rca_nbit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .cin (cin),
    .S   (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = c ? (sa - sb) : (sa + sb);
    return r[N:0];
  endfunction

  task automatic check(input string tag, input logic [N:0] expv);
    n_checks++;
    assert (S === expv) else begin
      n_fails++;
      $error("FAIL %s: observed S=%h expected %h", tag, S, expv);
    end
  endtask

  // Drive one operand set before an edge, then check the registered result after it.
  task automatic step(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, output logic [N:0] expv);
    @(negedge clk);
    A   = a;
    B   = b;
    cin = c;
    expv = ref_model(a, b, c);
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  initial begin
    logic [N:0] e;
    logic [N:0] held;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rc;
    n_checks = 0;
    n_fails  = 0;

    rst = 1'b1;
    A   = 32'd5;
    B   = 32'd3;
    cin = 1'b0;
    #1;
    check("reset_async", 33'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 33'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 33'd8);

    step("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, e);
    check("add_ovf_const", 33'h0_8000_0000);
    step("neg_extreme", 32'h8000_0000, 32'h8000_0000, 1'b0, e);
    check("neg_extreme_const", 33'h1_0000_0000);
    step("sub_min",     32'h0000_0000, 32'h8000_0000, 1'b1, e);
    check("sub_min_const", 33'h0_8000_0000);
    step("sub_self",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e);
    check("sub_self_const", 33'd0);
    step("mixed_add",   -32'sd7, 32'd12, 1'b0, e);
    check("mixed_add_const", 33'd5);
    step("mixed_sub",   -32'sd7, 32'd12, 1'b1, e);
    check("mixed_sub_const", -33'sd19);
    step("pos_extreme", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, e);
    check("pos_extreme_const", 33'h0_FFFF_FFFF);

    // Inputs changing between edges must not disturb the registered result.
    held = e;
    A   = 32'h1234_5678;
    B   = 32'h0BAD_F00D;
    cin = 1'b1;
    #2;
    check("hold_between_edges", held);

    // Asynchronous reset mid-operation clears at once and discards the coincident sample.
    step("pre_reset", 32'd100, 32'd50, 1'b0, e);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", 33'd0);
    @(posedge clk);
    #1;
    check("mid_reset_held", 33'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post_reset", 32'd100, 32'd50, 1'b1, e);

    for (int k = 0; k < 50; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      step($sformatf("rand_%0d", k), ra, rb, rc, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    n_fails++;
    $display("FAIL timeout: observed no completion, expected finish before 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
